uart_rx_core: RTL and testbench

// UART receiver, 8N1 by default: LSB first, 1 start bit, no parity, 1 stop bit.

---
 rtl/uart_rx_core.sv | 118 +++++++++++
 tb/tb_uart_rx_core.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1-style UART receiver: 2-flop synchronised input, mid-bit sampling timed
// from the start-bit falling edge, registered one-cycle data-valid strobe.
module uart_rx_core #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned WIDTH    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q;
    logic              rx_meta_q;
    logic              rx_sync_q;
    logic              armed_q;
    logic [CNT_W-1:0]  clk_cnt_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [WIDTH-1:0]  shift_q;
    logic [WIDTH-1:0]  data_q;
    logic              dv_q;

    assign o_data = data_q;
    assign o_dv   = dv_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // armed_q blocks a new start until the line has been seen high, so a
    // framing error (or a reset released mid-frame) cannot re-trigger on a held-low line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (rx_sync_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt_q == CNT_HALF_END) begin
                        clk_cnt_q <= '0;
                        state_q   <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == CNT_BIT_END) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_sync_q;
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt_q == CNT_BIT_END) begin
                        clk_cnt_q <= '0;
                        state_q   <= S_IDLE;
                        if (rx_sync_q) begin
                            data_q <= shift_q;
                            dv_q   <= 1'b1;
                        end else begin
                            armed_q <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core at default parameters (50 MHz, 115200 baud, 8 bits).
module tb_uart_rx_core;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       dv;

    int tests;
    int fails;
    int dv_cnt;
    logic [7:0] dv_log [16];

    uart_rx_core #(
        .CLK_FREQ(50_000_000),
        .BAUD    (115200),
        .WIDTH   (8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_rx   (rx),
        .o_data (data),
        .o_dv   (dv)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count strobe cycles and log the word presented with each one.
    always @(negedge clk) begin
        if (dv === 1'b1) begin
            dv_log[dv_cnt % 16] = data;
            dv_cnt++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int start_len, input int bit_len,
                              input logic stop_v, input int stop_len);
        rx = 1'b0;
        idle(start_len);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(bit_len);
        end
        rx = stop_v;
        idle(stop_len);
        rx = 1'b1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        dv_cnt = 0;
        rx     = 1'b1;
        rst_n  = 1'b0;
        idle(5);
        #1;
        check("reset_dv", int'(dv), 0);
        check("reset_data", int'(data), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        // Slow-start, fast-bit sender within tolerance
        send_frame(8'h37, 466, 416, 1'b1, 416);
        idle(5);
        check("f37_count", dv_cnt, 1);
        check("f37_data", int'(data), 8'h37);

        send_frame(8'h03, 466, 416, 1'b1, 416);
        idle(5);
        check("f03_count", dv_cnt, 2);
        check("f03_data", int'(data), 8'h03);
        check("f03_log", int'(dv_log[1]), 8'h03);

        // Short low glitch must be rejected at mid-start
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(600);
        check("glitch_count", dv_cnt, 2);
        check("glitch_data", int'(data), 8'h03);

        // Framing error: stop bit low
        send_frame(8'hA5, 434, 434, 1'b0, 434);
        idle(200);
        check("ferr_count", dv_cnt, 2);
        check("ferr_data", int'(data), 8'h03);

        send_frame(8'h5A, 434, 434, 1'b1, 434);
        idle(10);
        check("f5a_count", dv_cnt, 3);
        check("f5a_data", int'(data), 8'h5A);

        // Reset during data bit 4 of a 0xF0 frame
        rx = 1'b0;
        idle(434);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            idle(434);
        end
        rx = 1'b1;
        idle(200);
        rst_n = 1'b0;
        #1;
        check("midrst_dv", int'(dv), 0);
        check("midrst_data", int'(data), 8'h00);
        idle(5);
        rst_n = 1'b1;
        idle(1000);
        check("postrst_count", dv_cnt, 3);

        send_frame(8'hFF, 434, 434, 1'b1, 434);
        idle(10);
        check("fff_count", dv_cnt, 4);
        check("fff_data", int'(data), 8'hFF);

        // Back-to-back frames at the nominal bit period
        send_frame(8'h00, 434, 434, 1'b1, 434);
        send_frame(8'hFF, 434, 434, 1'b1, 434);
        idle(10);
        check("b2b_count", dv_cnt, 6);
        check("b2b_first", int'(dv_log[4]), 8'h00);
        check("b2b_second", int'(dv_log[5]), 8'hFF);
        check("b2b_data", int'(data), 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
